// File: rtl/kronos_dbus_wb_pkg.sv
// Shared types and helpers for the data-bus to Wishbone bridge.
//   dbus_state_e : bridge FSM states (idle, bus cycle in flight, ack pulse)
//   cnt_width    : width of the timeout counter for a given TIMEOUT
//   word_addr    : byte address to word-aligned address
package kronos_dbus_wb_pkg;

  typedef enum logic [1:0] {
    DBUS_IDLE = 2'd0,
    DBUS_BUS  = 2'd1,
    DBUS_DONE = 2'd2
  } dbus_state_e;

  // A zero TIMEOUT disables the watchdog, but the counter still needs one bit.
  function automatic int unsigned cnt_width(int unsigned timeout);
    int unsigned w;
    if (timeout == 0) begin
      w = 1;
    end else begin
      w = $clog2(timeout + 1);
    end
    return w;
  endfunction

  function automatic logic [31:0] word_addr(logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/kronos_dbus_wb_if.sv
// Signal bundle for the bridge: the core-side data port and the Wishbone B4
// classic master port.
//   master : the bridge (consumes core requests, drives the Wishbone cycle)
//   slave  : the environment (core request source and Wishbone slave)
interface kronos_dbus_wb_if;

  // Core data port
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic [31:0] data_rd_data;
  logic        data_ack;
  logic        data_err;

  // Wishbone port
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    input  data_addr, data_wr_data, data_mask, data_wr_en, data_req,
    output data_rd_data, data_ack, data_err,
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel,
    input  wb_dat_i, wb_ack, wb_err
  );

  modport slave (
    output data_addr, data_wr_data, data_mask, data_wr_en, data_req,
    input  data_rd_data, data_ack, data_err,
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel,
    output wb_dat_i, wb_ack, wb_err
  );

endinterface

// File: rtl/kronos_dbus_wb.sv
// Bridge from the core's req/ack data port to a Wishbone B4 classic master.
// Each accepted request is registered and runs exactly one bus cycle; the core
// gets a single-cycle data_ack (with data_err on slave error or timeout).
// Ports:
//   clk  : core clock
//   rst  : synchronous, active-high reset
//   bus  : kronos_dbus_wb_if.master (core data port + Wishbone master port)
// Parameters:
//   TIMEOUT : bus cycles to wait for wb_ack/wb_err before forcing an error;
//             0 disables the watchdog.
module kronos_dbus_wb
  import kronos_dbus_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  kronos_dbus_wb_if.master bus
);

  localparam int unsigned      CntW    = cnt_width(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  dbus_state_e     state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     rd_q, rd_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic timeout_hit;
  logic bus_done;
  logic bus_fail;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);
  assign bus_done    = bus.wb_ack || bus.wb_err || timeout_hit;
  // A slave ack on the last watchdog cycle still counts as a clean completion.
  assign bus_fail    = bus.wb_err || (timeout_hit && !bus.wb_ack);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      DBUS_IDLE: begin
        if (bus.data_req) begin
          adr_d   = word_addr(bus.data_addr);
          dat_d   = bus.data_wr_data;
          sel_d   = bus.data_mask;
          we_d    = bus.data_wr_en;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = DBUS_BUS;
        end
      end

      DBUS_BUS: begin
        if (bus_done) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = DBUS_DONE;
          if (bus_fail) begin
            rd_d  = '0;
            err_d = 1'b1;
          end else begin
            rd_d  = we_q ? 32'h0 : bus.wb_dat_i;
          end
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      // Ack pulse cycle; the core may still present the finished request here.
      DBUS_DONE: begin
        state_d = DBUS_IDLE;
      end

      default: begin
        state_d = DBUS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DBUS_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wb_cyc       = cyc_q;
  assign bus.wb_stb       = stb_q;
  assign bus.wb_we        = we_q;
  assign bus.wb_adr       = adr_q;
  assign bus.wb_dat_o     = dat_q;
  assign bus.wb_sel       = sel_q;
  assign bus.data_rd_data = rd_q;
  assign bus.data_ack     = ack_q;
  assign bus.data_err     = err_q;

endmodule

// File: tb/tb_kronos_dbus_wb.sv
// Self-checking bench for kronos_dbus_wb (TIMEOUT = 8): directed vector table,
// randomized accesses against a transaction-level model, held-request and
// mid-cycle reset sequences.
module tb_kronos_dbus_wb;

  localparam int unsigned TO = 8;

  // Slave behaviour per access: 0 ack, 1 err, 2 ack+err, 3 silent
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        we;
    int          waits;
    int          mode;
    logic [31:0] rdata;
  } acc_t;

  typedef struct {
    int          lat;
    logic [31:0] rd;
    logic        err;
    int          cyc_cycles;
  } exp_t;

  typedef struct {
    acc_t a;
    exp_t e;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  kronos_dbus_wb_if bus_if ();

  kronos_dbus_wb #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outcome from the access rules: slave ends the cycle after `waits` wait
  // states unless the watchdog (TO bus cycles) runs out first.
  function automatic exp_t model(input acc_t a);
    exp_t e;
    if (a.mode == 3 || a.waits > int'(TO) - 1) begin
      e.lat        = int'(TO) + 1;
      e.rd         = 32'h0;
      e.err        = 1'b1;
      e.cyc_cycles = int'(TO);
    end else begin
      e.lat        = a.waits + 2;
      e.err        = (a.mode == 1 || a.mode == 2);
      e.rd         = (e.err || a.we) ? 32'h0 : a.rdata;
      e.cyc_cycles = a.waits + 1;
    end
    return e;
  endfunction

  function automatic vec_t mkv(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] mask, input logic we, input int waits,
                               input int mode, input logic [31:0] rdata, input int lat,
                               input logic [31:0] rd, input logic err, input int cyc);
    vec_t v;
    v.a.addr  = addr;  v.a.wdata = wdata; v.a.mask  = mask; v.a.we = we;
    v.a.waits = waits; v.a.mode  = mode;  v.a.rdata = rdata;
    v.e.lat   = lat;   v.e.rd    = rd;    v.e.err   = err;  v.e.cyc_cycles = cyc;
    return v;
  endfunction

  // Issues one request at the current cycle, plays the slave and checks the
  // whole transaction. Returns one cycle after the ack pulse (req left high
  // when keep_req is set).
  task automatic run_access(input acc_t a, input exp_t e, input string tag,
                            input bit keep_req);
    int          cyc_n;
    int          rises;
    int          lat;
    logic        prev_cyc;
    logic        got;
    logic        stable;
    logic        cyc_at_ack;
    logic [31:0] rd_at_ack;
    logic        err_at_ack;
    logic [31:0] adr0;
    logic [31:0] dat0;
    logic [3:0]  sel0;
    logic        we0;

    bus_if.data_addr    = a.addr;
    bus_if.data_wr_data = a.wdata;
    bus_if.data_mask    = a.mask;
    bus_if.data_wr_en   = a.we;
    bus_if.data_req     = 1'b1;
    cyc_n = 0; rises = 0; lat = 0; prev_cyc = 1'b0; got = 1'b0; stable = 1'b1;
    cyc_at_ack = 1'b0; rd_at_ack = '0; err_at_ack = 1'b0;
    adr0 = '0; dat0 = '0; sel0 = '0; we0 = 1'b0;

    for (int c = 1; c <= 40 && !got; c++) begin
      step();
      if (bus_if.data_ack) begin
        got        = 1'b1;
        lat        = c;
        cyc_at_ack = bus_if.wb_cyc;
        rd_at_ack  = bus_if.data_rd_data;
        err_at_ack = bus_if.data_err;
      end
      if (bus_if.wb_stb !== bus_if.wb_cyc) stable = 1'b0;
      if (bus_if.wb_cyc) begin
        if (!prev_cyc) begin
          rises++;
          adr0 = bus_if.wb_adr; dat0 = bus_if.wb_dat_o;
          sel0 = bus_if.wb_sel; we0  = bus_if.wb_we;
        end else if (bus_if.wb_adr !== adr0 || bus_if.wb_dat_o !== dat0 ||
                     bus_if.wb_sel !== sel0 || bus_if.wb_we !== we0) begin
          stable = 1'b0;
        end
        bus_if.wb_ack   = (cyc_n == a.waits) && (a.mode == 0 || a.mode == 2);
        bus_if.wb_err   = (cyc_n == a.waits) && (a.mode == 1 || a.mode == 2);
        bus_if.wb_dat_i = (cyc_n == a.waits) ? a.rdata : $urandom;
        cyc_n++;
      end else begin
        bus_if.wb_ack = 1'b0;
        bus_if.wb_err = 1'b0;
      end
      prev_cyc = bus_if.wb_cyc;
    end
    bus_if.wb_ack = 1'b0;
    bus_if.wb_err = 1'b0;

    chk({tag, ".got_ack"}, 32'(got), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
    chk({tag, ".rd_data"}, rd_at_ack, e.rd);
    chk({tag, ".err"}, 32'(err_at_ack), 32'(e.err));
    chk({tag, ".cyc_at_ack"}, 32'(cyc_at_ack), 32'd0);
    chk({tag, ".cyc_cycles"}, 32'(cyc_n), 32'(e.cyc_cycles));
    chk({tag, ".bus_cycles"}, 32'(rises), 32'd1);
    chk({tag, ".stable"}, 32'(stable), 32'd1);
    chk({tag, ".wb_adr"}, adr0, {a.addr[31:2], 2'b00});
    chk({tag, ".wb_dat_o"}, dat0, a.wdata);
    chk({tag, ".wb_sel"}, 32'(sel0), 32'(a.mask));
    chk({tag, ".wb_we"}, 32'(we0), 32'(a.we));

    // Core samples the ack at this edge; no second pulse, no new bus cycle.
    step();
    chk({tag, ".ack_single"}, 32'(bus_if.data_ack), 32'd0);
    chk({tag, ".cyc_after_done"}, 32'(bus_if.wb_cyc), 32'd0);
    if (!keep_req) bus_if.data_req = 1'b0;
  endtask

  vec_t vecs [8];
  acc_t ra;
  int   quiet;
  int   gap;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    bus_if.data_addr    = '0;
    bus_if.data_wr_data = '0;
    bus_if.data_mask    = '0;
    bus_if.data_wr_en   = 1'b0;
    bus_if.data_req     = 1'b0;
    bus_if.wb_dat_i     = '0;
    bus_if.wb_ack       = 1'b0;
    bus_if.wb_err       = 1'b0;

    //             addr          wdata         mask   we waits mode rdata         lat rd            err cyc
    vecs[0] = mkv(32'h0000_0040, 32'h0,        4'hF,  0, 0, 0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 0, 1);
    vecs[1] = mkv(32'h0000_0104, 32'h00AB_CD00, 4'h6, 1, 3, 0, 32'h5A5A_5A5A, 5, 32'h0,         0, 4);
    vecs[2] = mkv(32'h0000_0200, 32'h0,        4'hF,  0, 1, 1, 32'hCAFE_F00D, 3, 32'h0,         1, 2);
    vecs[3] = mkv(32'h0000_0300, 32'h0,        4'hF,  0, 0, 3, 32'h1357_9BDF, 9, 32'h0,         1, 8);
    vecs[4] = mkv(32'h0000_0044, 32'h0,        4'hF,  0, 2, 0, 32'h1122_3344, 4, 32'h1122_3344, 0, 3);
    vecs[5] = mkv(32'h0000_0048, 32'h0000_0001, 4'hF, 1, 0, 2, 32'hFFFF_FFFF, 2, 32'h0,         1, 1);
    vecs[6] = mkv(32'h0000_010C, 32'h0,        4'h3,  0, 7, 0, 32'h0BAD_F00D, 9, 32'h0BAD_F00D, 0, 8);
    vecs[7] = mkv(32'h0000_0107, 32'h0,        4'hF,  0, 8, 0, 32'h2468_ACE0, 9, 32'h0,         1, 8);

    // Reset state
    step();
    step();
    chk("rst.wb_cyc", 32'(bus_if.wb_cyc), 32'd0);
    chk("rst.wb_stb", 32'(bus_if.wb_stb), 32'd0);
    chk("rst.wb_we", 32'(bus_if.wb_we), 32'd0);
    chk("rst.data_ack", 32'(bus_if.data_ack), 32'd0);
    chk("rst.data_err", 32'(bus_if.data_err), 32'd0);
    chk("rst.wb_adr", bus_if.wb_adr, 32'h0);
    chk("rst.wb_dat_o", bus_if.wb_dat_o, 32'h0);
    chk("rst.wb_sel", 32'(bus_if.wb_sel), 32'd0);
    chk("rst.rd_data", bus_if.data_rd_data, 32'h0);
    rst = 1'b0;
    step();

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i].a, vecs[i].e, $sformatf("vec%0d", i), 1'b0);
      step();
    end

    // Request held high across four back-to-back accesses
    for (int i = 0; i < 4; i++) begin
      ra.addr  = 32'h0000_1000 + 32'(i) * 32'h104;
      ra.wdata = 32'hA000_0000 + 32'(i);
      ra.mask  = 4'hF;
      ra.we    = (i == 2);
      ra.waits = i % 3;
      ra.mode  = 0;
      ra.rdata = 32'hB000_0000 + 32'(i);
      run_access(ra, model(ra), $sformatf("held%0d", i), 1'b1);
    end
    bus_if.data_req = 1'b0;
    step();

    // Reset while a silent slave keeps the bridge in BUS
    bus_if.data_addr  = 32'h0000_0500;
    bus_if.data_mask  = 4'hF;
    bus_if.data_wr_en = 1'b0;
    bus_if.data_req   = 1'b1;
    step();
    step();
    chk("midrst.cyc_before", 32'(bus_if.wb_cyc), 32'd1);
    rst             = 1'b1;
    bus_if.data_req = 1'b0;
    step();
    chk("midrst.wb_cyc", 32'(bus_if.wb_cyc), 32'd0);
    chk("midrst.wb_stb", 32'(bus_if.wb_stb), 32'd0);
    chk("midrst.data_ack", 32'(bus_if.data_ack), 32'd0);
    rst   = 1'b0;
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus_if.data_ack || bus_if.wb_cyc) quiet++;
    end
    chk("midrst.quiet", 32'(quiet), 32'd0);
    ra.addr = 32'h0000_0600; ra.wdata = '0; ra.mask = 4'hF; ra.we = 1'b0;
    ra.waits = 1; ra.mode = 0; ra.rdata = 32'h7777_1234;
    run_access(ra, model(ra), "midrst.after", 1'b0);

    // Randomized accesses against the model
    for (int i = 0; i < 40; i++) begin
      ra.addr  = $urandom;
      ra.wdata = $urandom;
      ra.mask  = 4'($urandom_range(1, 15));
      ra.we    = 1'($urandom_range(0, 1));
      ra.waits = int'($urandom_range(0, 9));
      ra.mode  = ($urandom_range(0, 5) < 3) ? 0 : int'($urandom_range(1, 3));
      ra.rdata = $urandom;
      run_access(ra, model(ra), $sformatf("rnd%0d", i), 1'b0);
      gap   = int'($urandom_range(0, 2));
      quiet = 0;
      for (int g = 0; g < gap; g++) begin
        step();
        if (bus_if.data_ack || bus_if.wb_cyc) quiet++;
      end
      if (gap > 0) chk($sformatf("rnd%0d.gap_quiet", i), 32'(quiet), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/kronos_dbus_wb.md
Name: kronos_dbus_wb

Overview:
- Downstream neighbour of kronos_WB. Bridges the core's simple data port (data_req/data_ack) to a Wishbone B4 classic master port.
- Registers every request and runs exactly one bus cycle per request.
- Returns read data and a single-cycle ack to the core.
- Guards against hung slaves with a timeout, reporting error or timeout on a separate error pulse.

Parameters:
TIMEOUT, 255, bus cycles to wait for wb_ack/wb_err before forcing completion; 0 disables the timeout.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
data_addr  in  32  byte address from core; bits [1:0] are always 00
data_wr_data  in  32  store data
data_mask  in  4  byte enables
data_wr_en  in  1  1=store, 0=load
data_req  in  1  request; held with stable payload until data_ack is sampled
data_rd_data  out  32  load data; valid only while data_ack=1
data_ack  out  1  single-cycle completion pulse
data_err  out  1  coincident with data_ack when the access ended by wb_err or timeout
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_we  out  1  write enable
wb_adr  out  32  word address; bits [1:0] forced 0
wb_dat_o  out  32  write data
wb_sel  out  4  byte selects
wb_dat_i  in  32  read data
wb_ack  in  1  slave ack
wb_err  in  1  slave error

Behaviour:
- Reset values (asserted on any clk edge with rst=1):
  - FSM to IDLE.
  - wb_cyc, wb_stb, wb_we, data_ack, data_err = 0.
  - wb_adr, wb_dat_o, wb_sel, data_rd_data = 0.
  - Timeout counter = 0.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - On an edge with data_req=1: latch addr (with [1:0]=0), wr_data, mask and wr_en into wb_adr/wb_dat_o/wb_sel/wb_we.
  - Set wb_cyc=wb_stb=1, clear the counter, go to BUS.
- BUS:
  - wb_cyc/wb_stb stay high and all wb_* outputs stay stable.
  - On an edge with wb_ack=1:
    - Capture wb_dat_i into data_rd_data for loads; data_rd_data=0 for stores.
    - Drop cyc/stb, set data_ack=1, go to DONE.
  - On an edge with wb_err=1: same as wb_ack, but data_rd_data=0 and data_err=1.
  - If wb_ack and wb_err are both 1, the access is treated as an error.
  - Timeout: the counter increments every BUS cycle. When TIMEOUT!=0 and counter==TIMEOUT-1 with no ack/err, behave as wb_err.
  - Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
- DONE:
  - data_ack (and data_err if set) high for exactly this one cycle; go to IDLE unconditionally.
  - data_req is ignored in DONE. Because the core sees ack at the DONE edge, the request it presents next cycle is new.
- Latency: req sampled at edge 0 → stb high during cycle 1 → zero-wait slave acks at edge 1 → data_ack high in cycle 2.
  - Core request-to-ack is 2 cycles plus N slave wait states.
  - Back-to-back throughput: one access per 3 cycles.
- Outside BUS, wb_cyc=wb_stb=0. No pipelined or burst cycles; wb_stb never re-asserts within a cycle.
- Reset mid-operation: cyc/stb drop at the reset edge and no data_ack is produced. The slave must tolerate an abandoned cycle.
- data_ack is never high in two consecutive cycles. Exactly one data_ack occurs per accepted request.

Decomposition:
- kronos_types gains the typedef enum logic [1:0] {DBUS_IDLE, DBUS_BUS, DBUS_DONE} dbus_state_e.
- No sub-module. The timeout counter is inline.

Test Plan:
- Zero-wait slave, LW at 0x0000_0040 with slave returning 0xDEADBEEF:
  - wb_adr=0x40, wb_sel=4'hF, wb_we=0.
  - data_ack exactly 2 cycles after req, data_rd_data=0xDEADBEEF, data_err=0.
- Store at 0x0000_0104, mask 4'b0110, data 0x00ABCD00, slave with 3 wait states:
  - wb_we=1, wb_sel=4'b0110, wb_dat_o stable for 4 cycles.
  - data_ack 5 cycles after req, wb_cyc low the cycle after the slave ack.
- Slave asserts wb_err on a load → data_ack=1 with data_err=1 and data_rd_data=0, in the same cycle.
- Silent slave, TIMEOUT=8:
  - wb_cyc high exactly 8 cycles, then data_ack=data_err=1.
  - FSM back in IDLE; the next request completes normally.
- data_req held high continuously across 4 requests with changing addresses:
  - 4 distinct wb cycles with the correct wb_adr each, one data_ack pulse each, no duplicate bus cycle.
- rst asserted 2 cycles into a waiting BUS state:
  - wb_cyc/wb_stb=0 and data_ack=0 the next cycle.
  - A later req after reset completes with correct data.
